// File: rtl/stim_trace_recorder_pkg.sv
// rtl/stim_trace_recorder_pkg.sv - shared types and word layout for the stimulus trace recorder
package stim_trace_recorder_pkg;

  localparam int DEPTH_DEFAULT = 64;

  localparam int OBS_BIT = 7;
  localparam int STB_BIT = 6;
  localparam int X_MSB   = 5;
  localparam int X_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DRAIN   = 2'd3
  } state_e;

  function automatic logic [7:0] pack_word(input logic obs, input logic stb, input logic [5:0] x);
    logic [7:0] w;
    w                = '0;
    w[OBS_BIT]       = obs;
    w[STB_BIT]       = stb;
    w[X_MSB:X_LSB]   = x;
    return w;
  endfunction

endpackage

// File: rtl/stim_trace_recorder_trace_ram.sv
// rtl/stim_trace_recorder_trace_ram.sv - 1-write/1-read synchronous capture RAM
module stim_trace_recorder_trace_ram
  import stim_trace_recorder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Only the read register is reset; array contents stay undefined.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/stim_trace_recorder.sv
// rtl/stim_trace_recorder.sv - arm/trigger/capture/drain recorder of monitored stimulus words
module stim_trace_recorder
  import stim_trace_recorder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        arm,
  input  logic        stop,
  input  logic        mon_obs,
  input  logic        mon_stb,
  input  logic [5:0]  mon_x,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic [1:0]  state,
  output logic [AW:0] count,
  output logic        overflow
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_C    = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_P    = (AW)'(1);

  logic [1:0]    rst_sync_q;
  logic          rst_n;
  state_e        state_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          rd_valid_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] rd_ptr_d;
  logic [7:0]    word;
  logic          we;
  logic          re;
  logic          xfer;
  logic          last_word;
  logic          full_now;

  // Assertion passes straight through; release waits two clock edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign word      = pack_word(mon_obs, mon_stb, mon_x);
  assign xfer      = rd_valid_q & rd_ready;
  assign last_word = (({1'b0, rd_ptr_q} + ONE_C) == count_q);
  assign full_now  = (state_q == ST_CAPTURE) && ((count_q + ONE_C) == FULL_CNT);
  assign we        = ((state_q == ST_ARMED) && mon_stb && !stop) || (state_q == ST_CAPTURE);
  assign re        = (state_q == ST_CAPTURE) || (state_q == ST_DRAIN);

  // The RAM reads the address that will be current next cycle, so rd_data
  // already holds buffer[rd_ptr] on the first DRAIN cycle and after each transfer.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (xfer && !last_word) rd_ptr_d = rd_ptr_q + ONE_P;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      case (state_q)
        ST_IDLE: begin
          if (arm) begin
            state_q    <= ST_ARMED;
            count_q    <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
          end
        end
        ST_ARMED: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (mon_stb) begin
            state_q  <= ST_CAPTURE;
            wr_ptr_q <= ONE_P;
            count_q  <= ONE_C;
          end
        end
        ST_CAPTURE: begin
          count_q <= count_q + ONE_C;
          if (full_now) begin
            overflow_q <= 1'b1;
            state_q    <= ST_DRAIN;
            rd_valid_q <= 1'b1;
          end else begin
            wr_ptr_q <= wr_ptr_q + ONE_P;
            if (stop) begin
              state_q    <= ST_DRAIN;
              rd_valid_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (xfer && last_word) begin
            state_q    <= ST_IDLE;
            rd_valid_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  stim_trace_recorder_trace_ram #(
    .DEPTH(DEPTH)
  ) u_trace_ram (
    .clk_i  (clock),
    .rst_ni (rst_n),
    .we_i   (we),
    .waddr_i(wr_ptr_q),
    .wdata_i(word),
    .re_i   (re),
    .raddr_i(rd_ptr_d),
    .rdata_o(rd_data)
  );

  assign state    = state_q;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign rd_valid = rd_valid_q;

endmodule
